// File: rtl/shift_normalizer_8bit.sv
// Sequential left-normalizer: shifts an operand left one bit per cycle until
// bit 7 is set, returning the normalized value and the shift count.
module shift_normalizer_8bit #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  // Handshake: a transfer occurs on a rising edge where valid & ready are both
  // high; valid, once raised, holds with stable data until that edge.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [SHW-1:0]   shamt,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;
  logic             zero_r;
  logic             accept;

  assign accept = in_valid && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      zero_r <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            work   <= in;
            cnt    <= '0;
            zero_r <= (in == '0);
          end
        end
        SHIFT: begin
          work <= {work[WIDTH-2:0], 1'b0};
          cnt  <= cnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Leaving SHIFT is decided on the pre-shift bit 6, so the exit edge is the
  // one that lands the leading one in bit 7.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in == '0 || in[WIDTH-1]) state_nxt = DONE;
          else                         state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (work[WIDTH-2]) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign out       = work;
  assign shamt     = cnt;
  assign zero      = zero_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_shift_normalizer_8bit.sv
// Directed bench for shift_normalizer_8bit: reset, latency, backpressure,
// mid-operation reset and a full 256-value sweep against a reference model.
module tb_shift_normalizer_8bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic [2:0] shamt;
  logic       zero;
  logic [1:0] dbg_state;

  int checks;
  int failures;

  shift_normalizer_8bit #(.WIDTH(8), .SHW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .shamt     (shamt),
    .zero      (zero),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept v at E0, wait for out_valid (bounded), check latency and result,
  // then transfer with out_ready and check the return to IDLE.
  task automatic run_op(input logic [7:0] v, input int exp_k,
                        input logic [7:0] exp_out, input logic [2:0] exp_sh,
                        input logic exp_zero);
    int n;
    @(negedge clk);
    check("pre_in_ready", {31'd0, in_ready}, 32'd1);
    in       = v;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, exp_k);
    check("out", {24'd0, out}, {24'd0, exp_out});
    check("shamt", {29'd0, shamt}, {29'd0, exp_sh});
    check("zero", {31'd0, zero}, {31'd0, exp_zero});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] m_out;
    int         lz;
    int         n;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in        = 8'd5;
    out_ready = 1'b0;

    // Reset held for 3 edges with an operand offered
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out", {24'd0, out}, 32'd0);
      check("rst_shamt", {29'd0, shamt}, 32'd0);
      check("rst_zero", {31'd0, zero}, 32'd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_out_valid", {31'd0, out_valid}, 32'd0);

    // Already normalized, mid-range, worst case, zero
    run_op(8'd128, 0, 8'd128, 3'd0, 1'b0);
    run_op(8'd255, 0, 8'd255, 3'd0, 1'b0);
    run_op(8'd8,   4, 8'd128, 3'd4, 1'b0);
    run_op(8'd3,   6, 8'd192, 3'd6, 1'b0);
    run_op(8'd1,   7, 8'd128, 3'd7, 1'b0);
    run_op(8'd0,   0, 8'd0,   3'd0, 1'b1);

    // Backpressure with a competing operand offered throughout
    @(negedge clk);
    in       = 8'd16;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in = 8'd2;
    check("shift_in_ready", {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_latency", n, 3);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out", {24'd0, out}, 32'd128);
      check("bp_shamt", {29'd0, shamt}, 32'd3);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_drop_valid", {31'd0, out_valid}, 32'd0);
    check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);

    // Reset at E0+3 during a 7-shift operation
    in       = 8'd1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    check("abort_out", {24'd0, out}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("abort_no_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    run_op(8'd64, 1, 8'd128, 3'd1, 1'b0);

    // Full sweep against a leading-zero model
    for (int i = 0; i < 256; i++) begin
      v  = i[7:0];
      lz = 0;
      while (lz < 8 && v[7 - lz] == 1'b0) lz++;
      if (v == 8'd0) begin
        run_op(v, 0, 8'd0, 3'd0, 1'b1);
      end else begin
        m_out = v << lz;
        run_op(v, lz, m_out, lz[2:0], 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_normalizer_8bit.md
# shift_normalizer_8bit

Sequential normalizer: the inverse companion of the 8-bit barrel shifter. It accepts an 8-bit operand and shifts it left one bit per cycle until bit 7 is set. It returns the normalized value and the shift amount `shamt`. A logical right shift of `out` by `shamt` (the barrel shifter's 3-bit control) reproduces the original operand. It sits in front of the shifter in normalize/denormalize datapaths and uses valid/ready handshakes on both sides.

## Interface
- `WIDTH`, 8, operand width; this revision supports only 8.
- `SHW`, 3, shift-amount width, equal to log2(`WIDTH`); matches the barrel shifter `ctrl` width.
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst_n`  input  1  reset: synchronous, active-low; sampled on the rising edge of `clk`.
- `in_valid`  input  1  operand present on `in`.
- `in_ready`  output  1  block can accept an operand; equals (state==IDLE) & `rst_n`.
- `in`  input  WIDTH  operand to normalize.
- `out_valid`  output  1  result fields are valid and stable.
- `out_ready`  input  1  consumer takes the result.
- `out`  output  WIDTH  normalized operand: bit 7 is 1, unless `zero` is set.
- `shamt`  output  SHW  number of left shifts applied, 0..7.
- `zero`  output  1  operand was 0; `out`=0 and `shamt`=0.

## Operation
- FSM states: IDLE, SHIFT, DONE. Registers: `work[7:0]`, `cnt[2:0]`, `zero`, `state`.
- IDLE
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`&`in_ready`: `work`<=`in`, `cnt`<=0, and the next state depends on `in`:
    - `in`==0: `zero`<=1, go to DONE.
    - `in[7]`==1: `zero`<=0, go to DONE with `shamt`=0.
    - otherwise: `zero`<=0, go to SHIFT.
- SHIFT
  - Each cycle: `work`<=`work`<<1 (zero fill) and `cnt`<=`cnt`+1.
  - If `work[6]`==1, the shifted value has bit 7 set, so go to DONE on the same edge.
  - No other exit exists. The operand is nonzero here, so at most 7 shifts occur and `cnt` never wraps.
- DONE
  - `out_valid`=1.
  - `out`=`work`, `shamt`=`cnt`, `zero` are held constant while `out_ready`=0.
  - On `out_ready`=1: go to IDLE.
- `in_valid` is ignored in SHIFT and DONE; `in_ready`=0 there. Operations never overlap.
- `out`, `shamt` and `zero` are driven directly from the registers. Their values outside DONE are don't-care for consumers but must never be X after reset.
- Invariants for every accepted nonzero `in`:
  - (`out` >> `shamt`) == `in`
  - `out[7]`==1
  - `shamt` == number of leading zeros of `in`

## Timing
- Reset: `rst_n`=0 at an edge forces state=IDLE, `work`=0, `cnt`=0, `zero`=0. Resulting output values:
  - `out_valid`=0, `out`=0, `shamt`=0, `zero`=0.
  - `in_ready`=0 while `rst_n`=0, and 1 in the first cycle after release.
- Reset mid-SHIFT or in DONE aborts the operation. The pending result is discarded; no `out_valid` pulse appears.
- Latency, with E0 the accepting edge and k = leading zeros of `in`:
  - k=0 or `in`=0: `out_valid` rises after E0.
  - 1<=k<=7: `out_valid` rises after edge E0+k.
  - Worst case is `in`=1: 7 cycles after E0.
- Handshake: the result transfers on the edge where `out_valid`&`out_ready`. `out_valid` falls and `in_ready` rises after that same edge.
- Throughput: a new operand is accepted no earlier than one cycle after the result transfer, giving k+2 cycles per operand with `out_ready` held high.
- `out_ready` may be high before `out_valid`; it has no effect outside DONE.

## Test plan
- Reset: hold `rst_n`=0 for 3 edges with `in_valid`=1 and `in`=8'd5 -> `in_ready`=0, `out_valid`=0, `out`=0, `shamt`=0, `zero`=0; nothing accepted. After release, `in_ready`=1.
- Already normalized: `in`=8'd128 accepted at E0 -> after E0, `out`=128, `shamt`=0, `zero`=0. `in`=8'd255 -> `out`=255, `shamt`=0.
- Mid-range shifts:
  - `in`=8'd8 -> after E0+4, `out`=128, `shamt`=4.
  - `in`=8'd3 -> after E0+6, `out`=192, `shamt`=6.
  - `in`=8'd1 -> after E0+7, `out`=128, `shamt`=7.
- Zero operand: `in`=0 -> after E0, `zero`=1, `out`=0, `shamt`=0, `out_valid`=1.
- Backpressure and ignored input:
  - `in`=8'd16 with `out_ready`=0 for 5 cycles after `out_valid` -> `out`=128 and `shamt`=3 held stable.
  - A different `in` with `in_valid`=1 during SHIFT and DONE is not accepted.
  - Raising `out_ready` -> `out_valid` drops after that edge, and `in_ready` returns to 1.
- Reset mid-operation, plus random sweep:
  - `in`=8'd1, then `rst_n`=0 at E0+3 -> IDLE, no result emitted. A following `in`=8'd64 -> `out`=128, `shamt`=1.
  - Sweep all 256 values of `in` with the invariants checked against the barrel shifter model.
